// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer with one-shot / auto-reload
// modes and a maskable, level-held interrupt.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | COUNT <= PRESET
// CNT   | count down; COUNT==0 raises pending
// INT   | one-shot: clear EN, hold pending; auto-reload: drop pending, reload
module irq_timer #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;      // [0] EN, [2:1] MODE, [3] IM
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;

  logic wr_ctrl, wr_preset, auto_reload;

  assign wr_ctrl     = we && (addr == ADDR_CTRL);
  assign wr_preset   = we && (addr == ADDR_PRESET);
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // Next-state logic: a register write overrides any FSM action that cycle.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    if (wr_ctrl || wr_preset) begin
      if (wr_ctrl)   ctrl_d   = wdata[3:0];
      if (wr_preset) preset_d = wdata;
      state_d   = S_IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q[0]) state_d = S_LOAD;
        end
        S_LOAD: begin
          count_d = preset_q;
          state_d = S_CNT;
        end
        S_CNT: begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            pending_d = 1'b1;
            state_d   = S_INT;
          end
        end
        S_INT: begin
          if (auto_reload) begin
            pending_d = 1'b0;
            state_d   = S_LOAD;
          end else begin
            ctrl_d[0] = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // irq is registered from next-state values so it rises with pending.
    irq_d = ctrl_d[3] & pending_d;
  end

  // State and register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= PRESET_RST;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  // Zero-latency read mux; unmapped offset reads 0.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, ctrl_q};
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer: a schedule-based model (load edge,
// countdown by elapsed edges, interrupt edge) checked every cycle, plus
// directed scenarios with literal expectations.
module tb_irq_timer;

  localparam logic [31:0] PRST = 32'h10;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  irq_timer #(.PRESET_RST(PRST)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Timer behaviour expressed as a schedule: t_load is the edge at which
  // COUNT takes PRESET; the countdown, interrupt and reload/stop edges are
  // all derived from it by arithmetic.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pending;
  longint      t_load;
  longint      cyc;
  longint      n;

  initial cyc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ctrl    = 4'd0;
      m_preset  = PRST;
      m_count   = 32'd0;
      m_pending = 1'b0;
      t_load    = -1;
    end else begin
      cyc++;
      n = longint'(m_preset);
      if (we && (addr == 2'd0 || addr == 2'd1)) begin
        if (addr == 2'd0) m_ctrl = wdata[3:0];
        else              m_preset = wdata;
        m_pending = 1'b0;
        t_load    = m_ctrl[0] ? cyc + 2 : -1;
      end else if (t_load >= 0) begin
        if (cyc == t_load) begin
          m_count = m_preset;
        end else if (cyc > t_load && cyc <= t_load + n) begin
          m_count = m_preset - 32'(cyc - t_load);
        end else if (cyc == t_load + n + 1) begin
          m_pending = 1'b1;
        end else if (cyc == t_load + n + 2) begin
          if (m_ctrl[2:1] == 2'b01) begin
            m_pending = 1'b0;
            t_load    = cyc + 1;
          end else begin
            m_ctrl[0] = 1'b0;
            t_load    = -1;
          end
        end
      end
    end
  end

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("model_irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pending});
    chk("model_rdata", rdata, m_rdata(addr));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick(1);
    we    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    int last;
    int npulse;
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;

    // Reset values, asserted before any clock edge.
    #1 reset = 1'b0;
    #1 chk_irq("rst_irq", 1'b0);
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, 32'h10);
    rd("rst_count", 2'd2, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // One-shot, PRESET=5, IM=1.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'b1001);                // edge k
    tick(2);
    rd("os_count_k2", 2'd2, 32'd5);
    tick(5);
    rd("os_count_k7", 2'd2, 32'd0);
    chk_irq("os_irq_k7", 1'b0);
    tick(1);
    chk_irq("os_irq_k8", 1'b1);
    tick(1);
    rd("os_ctrl_k9", 2'd0, 32'b1000);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_irq("os_irq_held", 1'b1);
    end
    wr(2'd0, 32'd0);
    chk_irq("os_irq_drop", 1'b0);
    tick(2);

    // Auto-reload, PRESET=2: pulses every 5 edges.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'b1011);
    last   = 0;
    npulse = 0;
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      if (irq) begin
        if (npulse == 0) chk("ar_first", i, 5);
        else             chk("ar_period", i - last, 5);
        last = i;
        npulse++;
      end
    end
    chk("ar_npulse", npulse, 5);
    wr(2'd0, 32'd0);
    tick(2);

    // Masked one-shot, PRESET=3, then unmask.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'b0001);
    tick(6);
    rd("mask_count0", 2'd2, 32'd0);
    chk_irq("mask_irq_k6", 1'b0);
    tick(2);
    rd("mask_ctrl_en0", 2'd0, 32'd0);
    chk_irq("mask_irq_k8", 1'b0);
    wr(2'd0, 32'b1001);
    tick(2);
    rd("mask_reload", 2'd2, 32'd3);
    tick(3);
    chk_irq("mask_irq_k5", 1'b0);
    tick(1);
    chk_irq("mask_irq_k6b", 1'b1);
    wr(2'd0, 32'd0);
    tick(2);

    // PRESET=0: interrupt 3 edges after enable.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'b1001);
    tick(2);
    chk_irq("p0_irq_k2", 1'b0);
    tick(1);
    chk_irq("p0_irq_k3", 1'b1);
    wr(2'd0, 32'd0);
    tick(2);

    // Write collision with the COUNT==0 detection edge.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'b1001);                // edge k; COUNT==0 seen at k+7
    tick(6);
    wr(2'd1, 32'd7);                   // lands on edge k+7
    chk_irq("col_no_irq", 1'b0);
    tick(2);
    rd("col_count", 2'd2, 32'd7);
    tick(7);
    chk_irq("col_irq_w9", 1'b0);
    tick(1);
    chk_irq("col_irq_w10", 1'b1);
    wr(2'd0, 32'd0);
    tick(2);

    // Ignored write to COUNT, then mid-count reset.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'b1001);                // edge k
    tick(4);
    rd("ign_count_k4", 2'd2, 32'd8);
    wr(2'd2, 32'hFFFF);                // edge k+5
    rd("ign_count_k5", 2'd2, 32'd7);
    tick(1);
    rd("ign_count_k6", 2'd2, 32'd6);
    rd("unmapped_rd", 2'd3, 32'd0);
    wr(2'd3, 32'hFFFF);
    rd("ign_count_k7", 2'd2, 32'd5);
    reset = 1'b0;
    #1;
    rd("mrst_count", 2'd2, 32'd0);
    chk_irq("mrst_irq", 1'b0);
    rd("mrst_preset", 2'd1, 32'h10);
    tick(1);
    reset = 1'b1;
    tick(20);
    rd("mrst_no_resume", 2'd2, 32'd0);
    chk_irq("mrst_irq_late", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
